uart_tx_feeder: RTL and testbench

UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_sync_fifo.sv | 84 ++++++++
 rtl/uart_tx_feeder.sv | 112 +++++++++++
 tb/tb_uart_tx_feeder.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit feeder: default sizing and the
// launch-sequencer state encoding.
package uart_pkg;

  localparam int DEFAULT_FEEDER_DEPTH = 8;
  localparam int DEFAULT_BUSY_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } feeder_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO with registered occupancy flags. A write is refused
// whenever the FIFO is full, even if a pop happens in the same cycle, and the
// refusal is reported as a one-cycle overflow pulse.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FEEDER_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr_en,
  input  logic [7:0]               i_wr_data,
  input  logic                     i_pop,
  output logic [7:0]               o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_full;
  logic          r_empty;
  logic          r_overflow;

  logic          w_push;
  logic          w_pop;
  logic [AW:0]   w_count_next;

  assign w_push = i_wr_en && !r_full;
  assign w_pop  = i_pop && !r_empty;

  // Next occupancy: a simultaneous push and pop cancel out.
  always_comb begin
    // NOTE: default assigned first so every path drives the signal and no latch is inferred.
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + CNT_ONE;
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - CNT_ONE;
    end
  end

  // Pointers, occupancy and flags; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_count    <= w_count_next;
      r_full     <= (w_count_next == CNT_FULL);
      r_empty    <= (w_count_next == '0);
      r_overflow <= i_wr_en && r_full;
    end
  end

  // Byte storage.
  always_ff @(posedge clk) begin
    // NOTE: the array is deliberately not reset; pointers and count alone define which entries are valid.
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  assign o_rd_data  = r_mem[r_rd_ptr];
  assign o_full     = r_full;
  assign o_empty    = r_empty;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers host bytes and launches them one at a time into a UART transmitter.
// A byte leaves the FIFO only once the transmitter acknowledges it by raising
// TX_BUSSY; if that never happens the byte is relaunched and timeout sticks.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH        = DEFAULT_FEEDER_DEPTH,
  parameter int BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               TX_BYTE,
  output logic                     TX_VALID,
  input  logic                     TX_BUSSY,
  output logic                     timeout
);

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(BUSY_TIMEOUT - 1);
  localparam logic [TW-1:0] TO_ONE  = TW'(1);

  feeder_state_e r_state;
  feeder_state_e w_state_next;
  logic [7:0]    r_tx_byte;
  logic [TW-1:0] r_to_cnt;
  logic [TW-1:0] w_to_cnt_next;
  logic          r_timeout;
  logic          w_load;
  logic          w_pop;
  logic          w_timeout_set;
  logic          w_tx_valid;
  logic [7:0]    w_head;

  uart_sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_wr_en    (wr_en),
    .i_wr_data  (wr_data),
    .i_pop      (w_pop),
    .o_rd_data  (w_head),
    .o_full     (full),
    .o_empty    (empty),
    .o_count    (count),
    .o_overflow (overflow)
  );

  // Launch sequencer: next state, launch strobe, pop and busy-wait timing.
  always_comb begin
    w_state_next  = r_state;
    w_to_cnt_next = r_to_cnt;
    w_load        = 1'b0;
    w_pop         = 1'b0;
    w_timeout_set = 1'b0;
    w_tx_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!empty && !TX_BUSSY) begin
          w_load       = 1'b1;
          w_state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        w_tx_valid    = 1'b1;
        w_to_cnt_next = '0;
        w_state_next  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (TX_BUSSY) begin
          w_pop        = 1'b1;
          w_state_next = WAIT_DONE;
        end else if (r_to_cnt == TO_LAST) begin
          w_timeout_set = 1'b1;
          w_state_next  = IDLE;
        end else begin
          w_to_cnt_next = r_to_cnt + TO_ONE;
        end
      end
      WAIT_DONE: begin
        if (!TX_BUSSY) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State, launched byte (held until the next launch), wait counter and sticky timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_tx_byte <= 8'h00;
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_to_cnt <= w_to_cnt_next;
      if (w_load)        r_tx_byte <= w_head;
      if (w_timeout_set) r_timeout <= 1'b1;
    end
  end

  assign TX_BYTE  = r_tx_byte;
  assign TX_VALID = w_tx_valid;
  assign timeout  = r_timeout;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with hand-derived expectations.
module tb_uart_tx_feeder;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic [7:0]    TX_BYTE;
  logic          TX_VALID;
  logic          TX_BUSSY;
  logic          timeout;

  logic          tb_busy  = 1'b0;
  logic          emu_en   = 1'b0;
  logic          emu_busy = 1'b0;
  int            emu_cnt  = 0;

  int checks   = 0;
  int failures = 0;

  logic [7:0] log_q[$];

  assign TX_BUSSY = emu_en ? emu_busy : tb_busy;

  always #5 clk = ~clk;

  uart_tx_feeder #(
    .DEPTH        (DEPTH),
    .BUSY_TIMEOUT (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .TX_BYTE  (TX_BYTE),
    .TX_VALID (TX_VALID),
    .TX_BUSSY (TX_BUSSY),
    .timeout  (timeout)
  );

  // Record every launched byte.
  always @(negedge clk) begin
    if (TX_VALID) log_q.push_back(TX_BYTE);
  end

  // Transmitter model: busy rises two cycles after a launch and stays up three cycles.
  always @(negedge clk) begin
    if (!emu_en) begin
      emu_cnt  = 0;
      emu_busy = 1'b0;
    end else begin
      if (TX_VALID)          emu_cnt = 5;
      else if (emu_cnt != 0) emu_cnt = emu_cnt - 1;
      emu_busy = (emu_cnt >= 1) && (emu_cnt <= 3);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    tb_busy = 1'b0;
    emu_en  = 1'b0;
    tick();
    rst = 1'b0;
    log_q.delete();
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (TX_VALID) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    wr_en = 1'b1; wr_data = 8'hFF; tb_busy = 1'b0;
    tick();
    do_reset();
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty: got %b expected 1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full: got %b expected 0", full); end
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (TX_VALID !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", TX_VALID); end
    checks++; if (TX_BYTE !== 8'h00) begin failures++; $display("FAIL reset_byte: got %h expected 00", TX_BYTE); end
    checks++; if ({overflow, timeout} !== 2'b00) begin failures++; $display("FAIL reset_flags: got %b expected 00", {overflow, timeout}); end
  endtask

  task automatic test_single();
    do_reset();
    wr_en = 1'b1; wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    checks++; if (count !== 4'd1 || empty !== 1'b0) begin failures++; $display("FAIL single_after_write: got count=%0d empty=%b expected 1/0", count, empty); end
    checks++; if (TX_VALID !== 1'b0) begin failures++; $display("FAIL single_early_launch: got %b expected 0", TX_VALID); end
    tick();
    checks++; if (TX_VALID !== 1'b1 || TX_BYTE !== 8'hA5) begin failures++; $display("FAIL single_launch: got valid=%b byte=%h expected 1/a5", TX_VALID, TX_BYTE); end
    tick();
    checks++; if (TX_VALID !== 1'b0) begin failures++; $display("FAIL single_valid_width: got %b expected 0", TX_VALID); end
    tick();
    tb_busy = 1'b1;
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL single_before_pop: got %0d expected 1", count); end
    tick();
    checks++; if (count !== 4'd0 || TX_BYTE !== 8'hA5) begin failures++; $display("FAIL single_pop: got count=%0d byte=%h expected 0/a5", count, TX_BYTE); end
    repeat (9) tick();
    tb_busy = 1'b0;
    repeat (6) tick();
    checks++; if (log_q.size() !== 1) begin failures++; $display("FAIL single_pulses: got %0d expected 1", log_q.size()); end
    else begin
      checks++; if (log_q[0] !== 8'hA5) begin failures++; $display("FAIL single_logged: got %h expected a5", log_q[0]); end
    end
  endtask

  task automatic test_overflow();
    logic [CW-1:0] exp_cnt;
    int            wait_cyc;
    int            bad;
    do_reset();
    tb_busy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wr_en = 1'b1; wr_data = 8'(i + 1);
      tick();
      exp_cnt = (i >= 7) ? 4'd8 : CW'(i + 1);
      checks++; if (count !== exp_cnt) begin failures++; $display("FAIL ovf_count[%0d]: got %0d expected %0d", i, count, exp_cnt); end
      checks++; if (full !== (i >= 7)) begin failures++; $display("FAIL ovf_full[%0d]: got %b expected %b", i, full, (i >= 7)); end
      checks++; if (overflow !== (i == 8)) begin failures++; $display("FAIL ovf_pulse[%0d]: got %b expected %b", i, overflow, (i == 8)); end
    end
    wr_en = 1'b0;
    tick();
    checks++; if (overflow !== 1'b0 || count !== 4'd8) begin failures++; $display("FAIL ovf_after: got ovf=%b count=%0d expected 0/8", overflow, count); end
    emu_en = 1'b1;
    wait_cyc = 0;
    while (!(log_q.size() >= 8 && empty) && wait_cyc < 300) begin tick(); wait_cyc++; end
    repeat (8) tick();
    checks++; if (log_q.size() !== 8) begin failures++; $display("FAIL ovf_drain_size: got %0d expected 8", log_q.size()); end
    else begin
      bad = 0;
      for (int i = 0; i < 8; i++) if (log_q[i] !== 8'(i + 1)) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL ovf_drain_order: got %0d wrong bytes expected 0", bad); end
    end
  endtask

  task automatic test_burst();
    logic [7:0] exp_b;
    int         wait_cyc;
    do_reset();
    emu_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h10 + i);
      tick();
    end
    wr_en = 1'b0;
    wait_cyc = 0;
    while (!(log_q.size() >= 3 && empty) && wait_cyc < 200) begin tick(); wait_cyc++; end
    repeat (10) tick();
    checks++; if (log_q.size() !== 3) begin failures++; $display("FAIL burst_size: got %0d expected 3", log_q.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        exp_b = 8'(8'h10 + i);
        checks++; if (log_q[i] !== exp_b) begin failures++; $display("FAIL burst_byte[%0d]: got %h expected %h", i, log_q[i], exp_b); end
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    wr_en = 1'b1; wr_data = 8'h3C;
    tick();
    wr_en = 1'b0;
    tick();
    checks++; if (TX_VALID !== 1'b1) begin failures++; $display("FAIL to_first_launch: got %b expected 1", TX_VALID); end
    repeat (16) tick();
    checks++; if (timeout !== 1'b0 || TX_VALID !== 1'b0) begin failures++; $display("FAIL to_early: got timeout=%b valid=%b expected 0/0", timeout, TX_VALID); end
    tick();
    checks++; if (timeout !== 1'b1 || count !== 4'd1) begin failures++; $display("FAIL to_set: got timeout=%b count=%0d expected 1/1", timeout, count); end
    tick();
    checks++; if (TX_VALID !== 1'b1 || TX_BYTE !== 8'h3C) begin failures++; $display("FAIL to_relaunch: got valid=%b byte=%h expected 1/3c", TX_VALID, TX_BYTE); end
    checks++; if (count !== 4'd1 || timeout !== 1'b1) begin failures++; $display("FAIL to_hold: got count=%0d timeout=%b expected 1/1", count, timeout); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    tb_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h21 + i);
      tick();
    end
    wr_en = 1'b0;
    tb_busy = 1'b0;
    wait_valid(6, ok);
    checks++; if (!ok) begin failures++; $display("FAIL mid_launch_wait: got no TX_VALID expected launch"); end
    tb_busy = 1'b1;
    tick();
    tick();
    checks++; if (count !== 4'd3) begin failures++; $display("FAIL mid_queued: got %0d expected 3", count); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    log_q.delete();
    checks++; if (empty !== 1'b1 || count !== 4'd0 || full !== 1'b0) begin failures++; $display("FAIL mid_flush: got empty=%b count=%0d full=%b expected 1/0/0", empty, count, full); end
    checks++; if (TX_VALID !== 1'b0 || TX_BYTE !== 8'h00) begin failures++; $display("FAIL mid_outputs: got valid=%b byte=%h expected 0/00", TX_VALID, TX_BYTE); end
    tb_busy = 1'b0;
    repeat (6) tick();
    checks++; if (log_q.size() !== 0) begin failures++; $display("FAIL mid_discard: got %0d launches expected 0", log_q.size()); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int sent;
    int wait_cyc;
    int bad;
    do_reset();
    tb_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h40 + i);
      tick();
    end
    wr_en = 1'b0;
    tb_busy = 1'b0;
    wait_valid(6, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_launch_wait: got no TX_VALID expected launch"); end
    tb_busy = 1'b1;
    tick();
    checks++; if (count !== 4'd3) begin failures++; $display("FAIL b2b_pre: got %0d expected 3", count); end
    wr_en = 1'b1; wr_data = 8'h43;
    tick();
    wr_en = 1'b0;
    checks++; if (count !== 4'd3 || full !== 1'b0 || empty !== 1'b0) begin failures++; $display("FAIL b2b_same_cycle: got count=%0d full=%b empty=%b expected 3/0/0", count, full, empty); end
    emu_en = 1'b1;
    sent = 0;
    for (int cyc = 0; cyc < 2000 && sent < 20; cyc++) begin
      if (!full) begin
        wr_en = 1'b1; wr_data = 8'(8'h44 + sent); sent++;
      end else begin
        wr_en = 1'b0;
      end
      tick();
    end
    wr_en = 1'b0;
    wait_cyc = 0;
    while (!(log_q.size() >= 24 && empty) && wait_cyc < 600) begin tick(); wait_cyc++; end
    repeat (8) tick();
    checks++; if (log_q.size() !== 24 || count !== 4'd0) begin failures++; $display("FAIL b2b_total: got %0d bytes count=%0d expected 24/0", log_q.size(), count); end
    else begin
      bad = 0;
      for (int i = 0; i < 24; i++) if (log_q[i] !== 8'(8'h40 + i)) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL b2b_order: got %0d wrong bytes expected 0", bad); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_burst();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
